// File: rtl/led_status_frontend_pkg.sv
// Shared types for the LED status front end: pulse FSM states, channel count, edge helper.
`include "led_status_defs.vh"

package led_status_frontend_pkg;

    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {
        S_IDLE = `ST_IDLE,
        S_HIGH = `ST_HIGH,
        S_GAP  = `ST_GAP
    } pulse_state_t;

    // UART lines idle high, so activity starts with a 1 -> 0 transition.
    function automatic logic is_fall(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

endpackage

// File: rtl/deb_filter.sv
// Synchronizer plus level debouncer: output follows the input only after it has been stable long enough.
module deb_filter
    import led_status_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   din_s;

    assign din_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            // Any sample agreeing with the current level restarts the stability window.
            if (din_s == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= ~dout;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_status_defs.vh
// Pulse FSM state encodings shared by the LED status front end.
`ifndef LED_STATUS_DEFS_VH
`define LED_STATUS_DEFS_VH
`define ST_IDLE 2'd0
`define ST_HIGH 2'd1
`define ST_GAP  2'd2
`endif

// File: rtl/led_status_frontend.sv
// Conditions raw UART activity, power-good and fault inputs into clean LED driver signals.
module led_status_frontend
    import led_status_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 50000,
    parameter int PULSE_LEN   = 8,
    parameter int PEND_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx1_in,
    input  logic       rx2_in,
    input  logic       pwr_good_in,
    input  logic       fault_in,
    input  logic       alarm_clr,
    output logic       RX1_led,
    output logic       RX2_led,
    output logic       led_POWER,
    output logic       led_Avariya,
    output logic [1:0] pend_ovf
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(PULSE_LEN - 1);
    // The gap holds one extra decision cycle, so low time is never shorter than the pulse.
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(PULSE_LEN);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    logic [NUM_CH-1:0] rx_raw;
    logic [NUM_CH-1:0] ch_led;
    logic [NUM_CH-1:0] ch_ovf;
    logic              pwr_deb;
    logic              fault_deb;
    logic              alarm_q;

    assign rx_raw = {rx2_in, rx1_in};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   edge_det;
        logic                   pend_full;
        pulse_state_t           state;
        logic [CNT_W-1:0]       cnt;
        logic [PEND_W-1:0]      pend;
        logic                   led_q;
        logic                   ovf_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '1;
                prev_q <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], rx_raw[g]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign edge_det  = is_fall(prev_q, sync_q[SYNC_STAGES-1]);
        assign pend_full = (pend == PEND_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= S_IDLE;
                cnt   <= '0;
                pend  <= '0;
                led_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                led_q <= (state == S_HIGH);
                case (state)
                    S_IDLE: begin
                        if (edge_det) begin
                            state <= S_HIGH;
                            cnt   <= '0;
                        end
                    end
                    S_HIGH: begin
                        if (cnt == HIGH_LAST) begin
                            state <= S_GAP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        if (edge_det) begin
                            if (pend_full) ovf_q <= 1'b1;
                            else           pend  <= pend + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            // A coincident edge replaces the pending one being consumed.
                            if (pend != '0) begin
                                state <= S_HIGH;
                                if (!edge_det) pend <= pend - 1'b1;
                            end else if (edge_det) begin
                                state <= S_HIGH;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (edge_det) begin
                                if (pend_full) ovf_q <= 1'b1;
                                else           pend  <= pend + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign ch_led[g] = led_q;
        assign ch_ovf[g] = ovf_q;
    end

    deb_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_pwr_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pwr_good_in),
        .dout (pwr_deb)
    );

    deb_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_fault_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (fault_in),
        .dout (fault_deb)
    );

    // Set has priority; a clear request during an active fault is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else if (fault_deb) begin
            alarm_q <= 1'b1;
        end else if (alarm_clr) begin
            alarm_q <= 1'b0;
        end
    end

    assign RX1_led     = ch_led[0];
    assign RX2_led     = ch_led[1];
    assign led_POWER   = pwr_deb;
    assign led_Avariya = alarm_q;
    assign pend_ovf    = ch_ovf;

endmodule
